beep_controller: RTL and testbench

- Drives the `beep` output of DigitalClock. Sits directly downstream of the time counter and mode FSM.
- Consumes the current time, a one-cycle seconds tick, the alarm setting and the debounced alarm-off pulse.
- Produces a short hourly chime burst and a gated, continuous alarm tone, both as a square wave at a fixed audio frequency.

---
 rtl/beep_controller_if.sv | 29 ++
 rtl/beep_controller.sv | 174 +++++++++++++++++
 tb/tb_beep_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beep_controller_if.sv
// Signal bundle between the time/mode logic and the beep controller.
// The master side supplies time, alarm setting and key pulses; the slave
// side (beep_controller) returns the buzzer drive and status flags.
interface beep_controller_if;
    logic       sec_tick;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       mode_normal;
    logic       alarm_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_off;
    logic       beep;
    logic       alarm_active;
    logic       chime_active;

    modport master (
        output sec_tick, hour, min, sec, mode_normal,
        output alarm_en, alarm_hour, alarm_min, alarm_off,
        input  beep, alarm_active, chime_active
    );

    modport slave (
        input  sec_tick, hour, min, sec, mode_normal,
        input  alarm_en, alarm_hour, alarm_min, alarm_off,
        output beep, alarm_active, chime_active
    );
endinterface

// File: rtl/beep_controller.sv
// Buzzer driver for the digital clock: a short chime on every full hour and
// a gated (500 ms on / 500 ms off) alarm tone that runs until the alarm-off
// key is pressed or a seconds-based timeout expires. Both sounds are a square
// wave at TONE_HZ. All outputs come straight from flops.
module beep_controller #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int TONE_HZ         = 2000,
    parameter int CHIME_MS        = 200,
    parameter int ALARM_TIMEOUT_S = 60
) (
    input logic              clk,
    input logic              rst,
    beep_controller_if.slave bus
);

    localparam int HALF      = CLK_FREQ / (2 * TONE_HZ);
    localparam int CHIME_CYC = CLK_FREQ / 1000 * CHIME_MS;
    localparam int GATE_HALF = CLK_FREQ / 2;

    localparam int DIV_W   = $clog2(HALF) + 1;
    localparam int CHIME_W = $clog2(CHIME_CYC) + 1;
    localparam int GATE_W  = $clog2(GATE_HALF) + 1;
    localparam int TO_W    = $clog2(ALARM_TIMEOUT_S) + 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(HALF - 1);
    localparam logic [CHIME_W-1:0] CHIME_LAST = CHIME_W'(CHIME_CYC - 1);
    localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_HALF - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(ALARM_TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHIME = 2'd1,
        ALARM = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               tick_d;
    logic               alarm_hit, chime_hit, entering;

    logic [DIV_W-1:0]   div_q, div_d;
    logic               tone_q, tone_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic               gate_q, gate_d;
    logic [CHIME_W-1:0] chime_cnt_q, chime_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

    logic               beep_q, beep_d;
    logic               alarm_active_q, chime_active_q;

    // Match detection, only on the cycle after a seconds tick so the time
    // inputs already carry their post-increment values.
    always_comb begin
        alarm_hit = tick_d & bus.mode_normal & bus.alarm_en
                  & (bus.hour == bus.alarm_hour)
                  & (bus.min  == bus.alarm_min)
                  & (bus.sec  == 6'd0);
        chime_hit = tick_d & bus.mode_normal
                  & (bus.min == 6'd0)
                  & (bus.sec == 6'd0);
    end

    // Next-state decision: alarm outranks chime, ALARM ignores further hits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (alarm_hit)      state_d = ALARM;
                else if (chime_hit) state_d = CHIME;
            end
            CHIME: begin
                if (alarm_hit)                     state_d = ALARM;
                else if (chime_cnt_q == CHIME_LAST) state_d = IDLE;
            end
            ALARM: begin
                if (bus.alarm_off)                      state_d = IDLE;
                else if (tick_d && (to_cnt_q == TO_LAST)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A CHIME -> ALARM preemption counts as entering ALARM.
        entering = (state_d != IDLE) && (state_d != state_q);
    end

    // Tone divider, alarm gate, chime length and timeout counters.
    always_comb begin
        div_d       = div_q;
        tone_d      = tone_q;
        gate_cnt_d  = gate_cnt_q;
        gate_d      = gate_q;
        chime_cnt_d = chime_cnt_q;
        to_cnt_d    = to_cnt_q;

        if (state_d == IDLE) begin
            div_d       = '0;
            tone_d      = 1'b0;
            gate_cnt_d  = '0;
            gate_d      = 1'b1;
            chime_cnt_d = '0;
            to_cnt_d    = '0;
        end else if (entering) begin
            // Every sound starts on the high half of the tone, gate open.
            div_d       = '0;
            tone_d      = 1'b1;
            gate_cnt_d  = '0;
            gate_d      = 1'b1;
            chime_cnt_d = '0;
            to_cnt_d    = '0;
        end else begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tone_d = ~tone_q;
            end else begin
                div_d = div_q + DIV_W'(1);
            end

            if (state_q == ALARM) begin
                if (gate_cnt_q == GATE_LAST) begin
                    gate_cnt_d = '0;
                    gate_d     = ~gate_q;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                end
                // The terminal tick leaves ALARM above, so this never
                // counts past TO_LAST.
                if (tick_d) to_cnt_d = to_cnt_q + TO_W'(1);
            end else begin
                // CHIME: continuous tone; the last count leaves CHIME above.
                gate_cnt_d  = '0;
                gate_d      = 1'b1;
                chime_cnt_d = chime_cnt_q + CHIME_W'(1);
            end
        end

        beep_d = (state_d != IDLE) & tone_d & gate_d;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from the values seen before the edge.
        if (rst) begin
            state_q        <= IDLE;
            tick_d         <= 1'b0;
            div_q          <= '0;
            tone_q         <= 1'b0;
            gate_cnt_q     <= '0;
            gate_q         <= 1'b1;
            chime_cnt_q    <= '0;
            to_cnt_q       <= '0;
            beep_q         <= 1'b0;
            alarm_active_q <= 1'b0;
            chime_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_d         <= bus.sec_tick;
            div_q          <= div_d;
            tone_q         <= tone_d;
            gate_cnt_q     <= gate_cnt_d;
            gate_q         <= gate_d;
            chime_cnt_q    <= chime_cnt_d;
            to_cnt_q       <= to_cnt_d;
            beep_q         <= beep_d;
            alarm_active_q <= (state_d == ALARM);
            chime_active_q <= (state_d == CHIME);
        end
    end

    assign bus.beep         = beep_q;
    assign bus.alarm_active = alarm_active_q;
    assign bus.chime_active = chime_active_q;

endmodule

// File: tb/tb_beep_controller.sv
// Directed bench for beep_controller with small parameters:
// HALF=5 cycles, chime 20 cycles, gate half-period 500 cycles, timeout 3 ticks.
module tb_beep_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    beep_controller_if bus ();

    beep_controller #(
        .CLK_FREQ        (1000),
        .TONE_HZ         (100),
        .CHIME_MS        (20),
        .ALARM_TIMEOUT_S (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {beep, alarm_active, chime_active}
    logic [2:0] outs;
    assign outs = {bus.beep, bus.alarm_active, bus.chime_active};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        bus.sec_tick = 1'b1;
        tick();
        bus.sec_tick = 1'b0;
    endtask

    task automatic pulse_off();
        bus.alarm_off = 1'b1;
        tick();
        bus.alarm_off = 1'b0;
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.hour = h;
        bus.min  = m;
        bus.sec  = s;
    endtask

    task automatic clear_inputs();
        bus.sec_tick    = 1'b0;
        bus.mode_normal = 1'b0;
        bus.alarm_en    = 1'b0;
        bus.alarm_hour  = 5'd0;
        bus.alarm_min   = 6'd0;
        bus.alarm_off   = 1'b0;
        set_time(5'd0, 6'd0, 6'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic arm_alarm(input logic [4:0] h, input logic [5:0] m);
        bus.mode_normal = 1'b1;
        bus.alarm_en    = 1'b1;
        bus.alarm_hour  = h;
        bus.alarm_min   = m;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: outs=%b expected=000", outs);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (outs !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle[%0d]: outs=%b expected=000", i, outs);
            end
            tick();
        end
    endtask

    task automatic test_chime();
        logic [2:0] exp;
        do_reset();
        bus.mode_normal = 1'b1;
        set_time(5'd1, 6'd0, 6'd0);
        pulse_tick();
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL chime_latency: outs=%b expected=000", outs);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            exp = {((i / 5) % 2 == 0), 1'b0, 1'b1};
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL chime_run[%0d]: outs=%b expected=%b", i, outs, exp);
            end
            tick();
        end
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL chime_end: outs=%b expected=000", outs);
        end
    endtask

    task automatic test_alarm_gate_off();
        logic [2:0] exp;
        do_reset();
        arm_alarm(5'd2, 6'd5);
        set_time(5'd2, 6'd5, 6'd0);
        pulse_tick();
        tick();
        for (int i = 0; i <= 1000; i++) begin
            exp = {(((i / 500) % 2 == 0) && ((i / 5) % 2 == 0)), 1'b1, 1'b0};
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL alarm_gate[%0d]: outs=%b expected=%b", i, outs, exp);
            end
            tick();
        end
        // Sample 1001: second gate-open window, tone high.
        checks++;
        if (outs !== 3'b110) begin
            errors++;
            $display("FAIL alarm_before_off: outs=%b expected=110", outs);
        end
        pulse_off();
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL alarm_off: outs=%b expected=000", outs);
        end
    endtask

    task automatic test_alarm_timeout();
        logic exp;
        do_reset();
        arm_alarm(5'd2, 6'd5);
        set_time(5'd2, 6'd5, 6'd0);
        pulse_tick();
        tick();
        checks++;
        if (outs !== 3'b110) begin
            errors++;
            $display("FAIL timeout_start: outs=%b expected=110", outs);
        end
        for (int k = 1; k <= 3; k++) begin
            bus.sec = 6'(k);
            pulse_tick();
            checks++;
            if (bus.alarm_active !== 1'b1) begin
                errors++;
                $display("FAIL timeout_pre[%0d]: alarm_active=%b expected=1", k, bus.alarm_active);
            end
            tick();
            exp = (k < 3);
            checks++;
            if (bus.alarm_active !== exp) begin
                errors++;
                $display("FAIL timeout_post[%0d]: alarm_active=%b expected=%b", k, bus.alarm_active, exp);
            end
        end
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL timeout_end: outs=%b expected=000", outs);
        end
    endtask

    task automatic test_alarm_priority();
        do_reset();
        arm_alarm(5'd1, 6'd0);
        set_time(5'd1, 6'd0, 6'd0);
        pulse_tick();
        tick();
        checks++;
        if (outs !== 3'b110) begin
            errors++;
            $display("FAIL prio_enter: outs=%b expected=110", outs);
        end
        for (int i = 0; i < 30; i++) begin
            checks++;
            if ({bus.alarm_active, bus.chime_active} !== 2'b10) begin
                errors++;
                $display("FAIL prio_hold[%0d]: alarm,chime=%b%b expected=10", i,
                         bus.alarm_active, bus.chime_active);
            end
            tick();
        end
        pulse_off();
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL prio_off: outs=%b expected=000", outs);
        end
    endtask

    task automatic test_preempt();
        logic [2:0] exp;
        do_reset();
        arm_alarm(5'd2, 6'd5);
        set_time(5'd3, 6'd0, 6'd0);
        pulse_tick();
        tick();
        checks++;
        if (outs !== 3'b101) begin
            errors++;
            $display("FAIL preempt_chime: outs=%b expected=101", outs);
        end
        repeat (7) tick();
        checks++;
        if (outs !== 3'b001) begin
            errors++;
            $display("FAIL preempt_low: outs=%b expected=001", outs);
        end
        set_time(5'd2, 6'd5, 6'd0);
        pulse_tick();
        tick();
        // Tone restarts high on entry to ALARM, gate open.
        for (int j = 0; j < 10; j++) begin
            exp = {(j < 5), 1'b1, 1'b0};
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL preempt_alarm[%0d]: outs=%b expected=%b", j, outs, exp);
            end
            tick();
        end
        pulse_off();
    endtask

    task automatic test_mode_gate();
        do_reset();
        arm_alarm(5'd1, 6'd0);
        // Time forced onto a match without a tick: nothing may fire.
        set_time(5'd1, 6'd0, 6'd0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (outs !== 3'b000) begin
                errors++;
                $display("FAIL no_tick[%0d]: outs=%b expected=000", i, outs);
            end
            tick();
        end
        bus.mode_normal = 1'b0;
        pulse_tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (outs !== 3'b000) begin
                errors++;
                $display("FAIL not_normal[%0d]: outs=%b expected=000", i, outs);
            end
            tick();
        end
    endtask

    task automatic test_alarm_disabled();
        do_reset();
        arm_alarm(5'd1, 6'd0);
        bus.alarm_en = 1'b0;
        set_time(5'd1, 6'd0, 6'd0);
        pulse_tick();
        tick();
        checks++;
        if (outs !== 3'b101) begin
            errors++;
            $display("FAIL dis_chime: outs=%b expected=101", outs);
        end
        repeat (3) tick();
        pulse_off();
        checks++;
        if ({bus.alarm_active, bus.chime_active} !== 2'b01) begin
            errors++;
            $display("FAIL dis_off_ignored: alarm,chime=%b%b expected=01",
                     bus.alarm_active, bus.chime_active);
        end
        bus.mode_normal = 1'b0;
        tick();
        checks++;
        if (bus.chime_active !== 1'b1) begin
            errors++;
            $display("FAIL mode_drop: chime_active=%b expected=1", bus.chime_active);
        end
        repeat (20) tick();
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL dis_end: outs=%b expected=000", outs);
        end
    endtask

    task automatic test_reset_mid_alarm();
        do_reset();
        arm_alarm(5'd2, 6'd5);
        set_time(5'd2, 6'd5, 6'd0);
        pulse_tick();
        tick();
        checks++;
        if (outs !== 3'b110) begin
            errors++;
            $display("FAIL rst_mid_enter: outs=%b expected=110", outs);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid: outs=%b expected=000", outs);
        end
        pulse_off();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs !== 3'b000) begin
                errors++;
                $display("FAIL rst_after_off[%0d]: outs=%b expected=000", i, outs);
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_chime();
        test_alarm_gate_off();
        test_alarm_timeout();
        test_alarm_priority();
        test_preempt();
        test_mode_gate();
        test_alarm_disabled();
        test_reset_mid_alarm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
